fetch_queue_stage: RTL and testbench

Parametrised instruction-fetch stage that decouples PC generation from decode with a DEPTH-entry fetch queue and a variable-latency instruction-memory request/response port. It issues sequential fetches ahead of decode, absorbs decode stalls without refetching, and squashes queued and in-flight fetches on a taken branch or jump. The head of the queue is presented to the decode stage as pre-split instruction fields plus a valid/ready handshake.

---
 rtl/fetch_queue_stage.sv | 150 +++++++++++++++
 tb/tb_fetch_queue_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_stage.sv
//==============================================================================
// fetch_queue_stage : credit-based instruction fetch with a DEPTH-entry queue
// Optional feature: FETCH_BYPASS_EN (same-cycle response-to-decode bypass)
// Revision: 1.0
//==============================================================================
`default_nettype none

module fetch_queue_stage #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  PCsrc_i,
   input  logic [31:0] pcPlusImm_i,
   input  logic [31:0] regPlusImm_i,
   input  logic        id_ready_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        valid_o,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output logic [4:0]  rd_o,
   output logic [24:0] Instr31_7_o,
   output logic [6:0]  op_o,
   output logic [2:0]  funct3_o,
   output logic [31:0] PC_o,
   output logic [31:0] pcPlus4_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int SW = CW + 1;

   logic [31:0]      r_fetch_pc;
   logic [31:0]      r_shadow_pc;
   logic [31:0]      r_q_instr [DEPTH];
   logic [31:0]      r_q_pc    [DEPTH];
   logic [DEPTH-1:0] r_q_live;
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    r_inflight;
   logic [CW-1:0]    r_drop;

   logic          w_redirect;
   logic [31:0]   w_target;
   logic [SW-1:0] w_credit_used;
   logic          w_accept;
   logic          w_q_empty;
   logic          w_keep;
   logic          w_bypass;
   logic          w_pop_q;
   logic          w_push;
   logic [31:0]   w_out_instr;
   logic [31:0]   w_out_pc;
   logic          w_out_live;

   assign w_redirect    = (PCsrc_i == 2'b01) || (PCsrc_i == 2'b10);
   assign w_target      = (PCsrc_i == 2'b10) ? {regPlusImm_i[31:2], 2'b00}
                                             : {pcPlusImm_i[31:2], 2'b00};
   assign w_credit_used = {1'b0, r_count} + {1'b0, r_inflight};

   // Requests are held low while reset is asserted, so the first one appears
   // in the cycle that reset is released.
   assign imem_req_o  = !rst_i && !w_redirect && (w_credit_used < SW'(DEPTH));
   assign imem_addr_o = r_fetch_pc;
   assign w_accept    = imem_req_o && imem_ready_i;

   assign w_q_empty = (r_count == '0);
   assign w_keep    = imem_rvalid_i && (r_drop == '0) && !w_redirect;

`ifdef FETCH_BYPASS_EN
   assign w_bypass = w_q_empty && w_keep;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_pop_q = !w_redirect && !w_q_empty && id_ready_i;
   assign w_push  = w_keep && !(w_bypass && id_ready_i);

   assign w_out_instr = w_bypass ? imem_rdata_i : r_q_instr[r_rptr];
   assign w_out_pc    = w_bypass ? r_shadow_pc  : r_q_pc[r_rptr];
   assign w_out_live  = w_bypass || r_q_live[r_rptr];

   assign valid_o     = !w_redirect && (!w_q_empty || w_bypass);
   assign rs1_o       = w_out_instr[19:15];
   assign rs2_o       = w_out_instr[24:20];
   assign rd_o        = w_out_instr[11:7];
   assign Instr31_7_o = w_out_instr[31:7];
   assign op_o        = w_out_instr[6:0];
   assign funct3_o    = w_out_instr[14:12];
   assign PC_o        = w_out_pc;
   // An entry never written since reset reports 0 here rather than 4.
   assign pcPlus4_o   = w_out_live ? (w_out_pc + 32'd4) : 32'd0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_fetch_pc  <= RESET_PC;
         r_shadow_pc <= RESET_PC;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_inflight  <= '0;
         r_drop      <= '0;
         r_q_live    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_q_instr[i] <= '0;
            r_q_pc[i]    <= '0;
         end
      end else begin
         r_inflight <= r_inflight + CW'(w_accept) - CW'(imem_rvalid_i);
         if (w_redirect) begin
            // Everything still outstanding, minus a response landing now, is stale.
            r_fetch_pc  <= w_target;
            r_shadow_pc <= w_target;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_drop      <= r_inflight - CW'(imem_rvalid_i);
         end else begin
            if (w_accept) begin
               r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (imem_rvalid_i && (r_drop != '0)) begin
               r_drop <= r_drop - CW'(1);
            end
            if (w_keep) begin
               r_shadow_pc <= r_shadow_pc + 32'd4;
            end
            if (w_push) begin
               r_q_instr[r_wptr] <= imem_rdata_i;
               r_q_pc[r_wptr]    <= r_shadow_pc;
               r_q_live[r_wptr]  <= 1'b1;
               r_wptr            <= r_wptr + AW'(1);
            end
            if (w_pop_q) begin
               r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop_q);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue_stage.sv
//==============================================================================
// tb_fetch_queue_stage : directed self-checking bench for fetch_queue_stage
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_fetch_queue_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic [1:0]  pcsrc = 2'b00;
   logic [31:0] pc_imm = '0;
   logic [31:0] reg_imm = '0;
   logic        id_ready = 1'b1;
   logic        ready = 1'b1;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = '0;
   logic        req, valid;
   logic [31:0] addr, pc, pc4;
   logic [4:0]  rs1, rs2, rd;
   logic [24:0] i31;
   logic [6:0]  op;
   logic [2:0]  f3;

   logic        rvalid2 = 1'b0;
   logic [31:0] rdata2 = '0;
   logic        req2, valid2;
   logic [31:0] addr2, pc2, pc4_2;
   logic [4:0]  rs1_2, rs2_2, rd_2;
   logic [24:0] i31_2;
   logic [6:0]  op2;
   logic [2:0]  f3_2;

   fetch_queue_stage #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk_i(clk), .rst_i(rst), .PCsrc_i(pcsrc), .pcPlusImm_i(pc_imm),
      .regPlusImm_i(reg_imm), .id_ready_i(id_ready), .imem_req_o(req),
      .imem_addr_o(addr), .imem_ready_i(ready), .imem_rvalid_i(rvalid),
      .imem_rdata_i(rdata), .valid_o(valid), .rs1_o(rs1), .rs2_o(rs2),
      .rd_o(rd), .Instr31_7_o(i31), .op_o(op), .funct3_o(f3), .PC_o(pc),
      .pcPlus4_o(pc4)
   );

   fetch_queue_stage #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk_i(clk), .rst_i(rst), .PCsrc_i(2'b00), .pcPlusImm_i(32'h0),
      .regPlusImm_i(32'h0), .id_ready_i(1'b1), .imem_req_o(req2),
      .imem_addr_o(addr2), .imem_ready_i(1'b1), .imem_rvalid_i(rvalid2),
      .imem_rdata_i(rdata2), .valid_o(valid2), .rs1_o(rs1_2), .rs2_o(rs2_2),
      .rd_o(rd_2), .Instr31_7_o(i31_2), .op_o(op2), .funct3_o(f3_2),
      .PC_o(pc2), .pcPlus4_o(pc4_2)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory image: address 0 holds 0x00500093 (addi x1,x0,5).
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h0050_0093;
   endfunction

   // In-order memory model with fixed latency; sampled mid-cycle, driven at edge+2.
   int          lat = 1;
   int          cyc = 0;
   logic        mem_flush = 1'b1;
   logic        acc_s = 1'b0, rsp_s = 1'b0, acc2_s = 1'b0;
   logic [31:0] addr_s = '0, addr2_s = '0;
   logic [31:0] mq_a[$];
   int          mq_due[$];

   always @(negedge clk) begin
      acc_s   = req && ready;
      addr_s  = addr;
      rsp_s   = rvalid;
      acc2_s  = req2;
      addr2_s = addr2;
   end

   always @(posedge clk) begin
      #2;
      cyc++;
      if (mem_flush) begin
         mq_a.delete();
         mq_due.delete();
         rvalid  = 1'b0;
         rdata   = '0;
         rvalid2 = 1'b0;
         rdata2  = '0;
      end else begin
         if (rsp_s && mq_a.size() > 0) begin
            void'(mq_a.pop_front());
            void'(mq_due.pop_front());
         end
         if (acc_s) begin
            mq_a.push_back(addr_s);
            mq_due.push_back(cyc - 1 + lat);
         end
         rvalid  = (mq_a.size() > 0) && (mq_due[0] <= cyc);
         rdata   = rvalid ? mem_word(mq_a[0]) : 32'h0;
         rvalid2 = acc2_s;
         rdata2  = acc2_s ? mem_word(addr2_s) : 32'h0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   // Leaves the bench at edge+1 of cycle 0 with reset released.
   task automatic do_reset();
      rst       = 1'b1;
      mem_flush = 1'b1;
      pcsrc     = 2'b00;
      samp();
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_req", 32'(req), 32'h0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_pc4", pc4, 32'h0);
      chk("rst_i31", 32'(i31), 32'h0);
      step();
      step();
      rst       = 1'b0;
      mem_flush = 1'b0;
   endtask

   task automatic wait_valid(input string tag, output int cycles);
      cycles = 0;
      while (!valid && cycles < 50) begin
         @(negedge clk);
         cycles++;
      end
      chk(tag, 32'(valid), 32'h1);
   endtask

   int nacc;
   int cy;

`ifdef FETCH_BYPASS_EN
   localparam int BP = 1;
`else
   localparam int BP = 0;
`endif

   initial begin
      // Sequential fetch, 1-cycle memory
      lat = 1; id_ready = 1'b1;
      do_reset();
      samp();
      chk("t1_req0", 32'(req), 32'h1);
      chk("t1_addr0", addr, 32'h0);
      wait_valid("t1_valid", cy);
      chk("t1_lat", 32'(cy), 32'(2 - BP));
      chk("t1_pc", pc, 32'h0);
      chk("t1_pc4", pc4, 32'h4);
      chk("t1_op", 32'(op), 32'h13);
      chk("t1_rd", 32'(rd), 32'h1);
      chk("t1_rs1", 32'(rs1), 32'h0);
      chk("t1_rs2", 32'(rs2), 32'h5);
      chk("t1_f3", 32'(f3), 32'h0);
      chk("t1_i31", 32'(i31), 32'h000A001);
      for (int i = 1; i < 4; i++) begin
         samp();
         chk("t1_seq_valid", 32'(valid), 32'h1);
         chk("t1_seq_pc", pc, 32'(4 * i));
      end
      chk("t1_seq_op", 32'(op), 32'h1F);

      // Decode stall fills credit, then drains in order
      id_ready = 1'b0;
      do_reset();
      nacc = 0;
      for (int i = 0; i < 10; i++) begin
         samp();
         if (req && ready) nacc++;
      end
      chk("t2_accepts", 32'(nacc), 32'h4);
      chk("t2_req_off", 32'(req), 32'h0);
      chk("t2_hold_valid", 32'(valid), 32'h1);
      chk("t2_hold_pc", pc, 32'h0);
      step();
      id_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         samp();
         chk("t2_drain_valid", 32'(valid), 32'h1);
         chk("t2_drain_pc", pc, 32'(4 * i));
      end

      // Redirect to pcPlusImm with 3 requests in flight, latency 3
      lat = 3;
      do_reset();
      step(); step(); step();
      pcsrc = 2'b01; pc_imm = 32'h0000_0100;
      samp();
      chk("t3_redir_req", 32'(req), 32'h0);
      chk("t3_redir_valid", 32'(valid), 32'h0);
      step();
      pcsrc = 2'b00;
      samp();
      chk("t3_req", 32'(req), 32'h1);
      chk("t3_addr", addr, 32'h100);
      wait_valid("t3_valid", cy);
      chk("t3_lat", 32'(cy), 32'(4 - BP));
      chk("t3_pc", pc, 32'h100);
      chk("t3_rd", 32'(rd), 32'h3);
      samp();
      chk("t3_pc_next", pc, 32'h104);

      // Redirect to regPlusImm while a response arrives and the queue is occupied
      lat = 1;
      do_reset();
      step(); step();
      pcsrc = 2'b10; reg_imm = 32'h0000_0203;
      samp();
      chk("t4_rsp_present", 32'(rvalid), 32'h1);
      chk("t4_redir_valid", 32'(valid), 32'h0);
      chk("t4_redir_req", 32'(req), 32'h0);
      step();
      pcsrc = 2'b00;
      samp();
      chk("t4_addr", addr, 32'h200);
      wait_valid("t4_valid", cy);
      chk("t4_lat", 32'(cy), 32'(2 - BP));
      chk("t4_pc", pc, 32'h200);

      // PC wrap-around from RESET_PC = 0xFFFF_FFFC
      do_reset();
      samp();
      chk("t5_addr0", addr2, 32'hFFFF_FFFC);
      samp();
      chk("t5_addr1", addr2, 32'h0);
      cy = 1;
      while (!valid2 && cy < 50) begin
         samp();
         cy++;
      end
      chk("t5_valid", 32'(valid2), 32'h1);
      chk("t5_pc", pc2, 32'hFFFF_FFFC);
      chk("t5_pc4", pc4_2, 32'h0);
      samp();
      chk("t5_pc_next", pc2, 32'h0);
      chk("t5_pc4_next", pc4_2, 32'h4);

`ifdef FETCH_BYPASS_EN
      // Same-cycle bypass of a response into an empty queue
      do_reset();
      samp();
      samp();
      chk("t6_valid", 32'(valid), 32'h1);
      chk("t6_op", 32'(op), 32'h13);
      chk("t6_rd", 32'(rd), 32'h1);
      chk("t6_rs1", 32'(rs1), 32'h0);
      chk("t6_f3", 32'(f3), 32'h0);
      chk("t6_pc", pc, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
